// File: rtl/ysyx_041461_scoreboard.sv
// Issue-stage scoreboard: per-GPR in-flight write counters, a small table of
// in-flight CSR writers, and a trap-drain FSM that holds issue until every
// in-flight write has retired.

// Per-GPR pending-write counter. It nets this cycle's issue against the
// releases from all writeback ports, and it clamps at zero on underflow.
module ysyx_041461_scoreboard_cnt #(
  parameter int RIDX_W = 5,
  parameter int CNT_W  = 2,
  parameter int NWB    = 2,
  parameter int IDX    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  flush,
  input  logic [NWB-1:0]        wb_valid,
  input  logic [NWB*RIDX_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      cnt,
  output logic [CNT_W-1:0]      cnt_nxt,
  output logic                  uf
);
  localparam int SW = CNT_W + $clog2(NWB + 1) + 1;

  logic [SW-1:0] dec, sum;

  // Count the ports releasing this register, then net the result against the issue.
  always_comb begin
    dec = '0;
    for (int k = 0; k < NWB; k++)
      if (wb_valid[k] && wb_rd[k*RIDX_W +: RIDX_W] == RIDX_W'(IDX))
        dec = dec + SW'(1);
    sum     = SW'(cnt) + SW'(inc);
    uf      = sum < dec;
    cnt_nxt = uf ? '0 : CNT_W'(sum - dec);
    // flush squashes the whole cycle, so a release cannot flag an underflow here
    if (flush) begin
      cnt_nxt = '0;
      uf      = 1'b0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
endmodule

module ysyx_041461_scoreboard #(
  parameter int NREG   = 32,
  parameter int RIDX_W = 5,
  parameter int CNT_W  = 2,
  parameter int NWB    = 2,
  parameter int NCSR   = 4,
  parameter int CSR_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic                  iss_rs1_re,
  input  logic                  iss_rs2_re,
  input  logic [RIDX_W-1:0]     iss_rs1,
  input  logic [RIDX_W-1:0]     iss_rs2,
  input  logic                  iss_rd_we,
  input  logic [RIDX_W-1:0]     iss_rd,
  input  logic                  iss_csr_re,
  input  logic                  iss_csr_we,
  input  logic [CSR_W-1:0]      iss_csr,
  output logic                  iss_stall,
  input  logic [NWB-1:0]        wb_valid,
  input  logic [NWB*RIDX_W-1:0] wb_rd,
  input  logic                  csr_rel_valid,
  input  logic [CSR_W-1:0]      csr_rel_addr,
  input  logic                  flush,
  input  logic                  trap_req,
  output logic                  trap_ack,
  output logic                  busy,
  output logic                  err_underflow
);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0]                        state;
  logic [NREG-1:0][CNT_W-1:0]        cnt, cnt_nxt;
  logic [NREG-1:0]                   gpr_uf;
  logic [NCSR-1:0]                   csr_vld, csr_vld_nxt;
  logic [NCSR-1:0][CSR_W-1:0]        csr_addr, csr_addr_nxt;
  logic                              csr_hit, csr_full, rel_uf, fire;
  logic                              raw1, raw2, waw;

  // x0 is hardwired: it has no counter, so it never stalls and never underflows.
  assign cnt[0]     = '0;
  assign cnt_nxt[0] = '0;
  assign gpr_uf[0]  = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_gpr
    ysyx_041461_scoreboard_cnt #(
      .RIDX_W (RIDX_W),
      .CNT_W  (CNT_W),
      .NWB    (NWB),
      .IDX    (i)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (fire && iss_rd_we && iss_rd == RIDX_W'(i)),
      .flush    (flush),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .cnt      (cnt[i]),
      .cnt_nxt  (cnt_nxt[i]),
      .uf       (gpr_uf[i])
    );
  end

  // Hazard detection reads only registered state, so a release in this cycle cannot clear this cycle's stall.
  always_comb begin
    csr_hit  = 1'b0;
    csr_full = &csr_vld;
    for (int i = 0; i < NCSR; i++)
      if (csr_vld[i] && csr_addr[i] == iss_csr) csr_hit = 1'b1;
    raw1 = iss_rs1_re && iss_rs1 != '0 && cnt[iss_rs1] != '0;
    raw2 = iss_rs2_re && iss_rs2 != '0 && cnt[iss_rs2] != '0;
    waw  = iss_rd_we  && iss_rd  != '0 && cnt[iss_rd] == '1;
    iss_stall = iss_valid && (state != S_RUN || trap_req || raw1 || raw2 || waw ||
                              ((iss_csr_re || iss_csr_we) && csr_hit) ||
                              (iss_csr_we && csr_full));
    fire = iss_valid && !iss_stall;
  end

  // CSR table next state: retire the lowest matching entry and allocate the lowest free entry, both based on this cycle's table
  always_comb begin
    logic found, done;
    csr_vld_nxt  = csr_vld;
    csr_addr_nxt = csr_addr;
    rel_uf       = 1'b0;
    found        = 1'b0;
    done         = 1'b0;
    if (csr_rel_valid) begin
      for (int i = 0; i < NCSR; i++)
        if (!found && csr_vld[i] && csr_addr[i] == csr_rel_addr) begin
          csr_vld_nxt[i] = 1'b0;
          found          = 1'b1;
        end
      rel_uf = !found;
    end
    if (fire && iss_csr_we)
      for (int i = 0; i < NCSR; i++)
        if (!done && !csr_vld[i]) begin
          csr_vld_nxt[i]  = 1'b1;
          csr_addr_nxt[i] = iss_csr;
          done            = 1'b1;
        end
    if (flush) begin
      csr_vld_nxt = '0;
      rel_uf      = 1'b0;
    end
  end

  // CSR table, busy summary, and sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_vld       <= '0;
      csr_addr      <= '0;
      busy          <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      csr_vld       <= csr_vld_nxt;
      csr_addr      <= csr_addr_nxt;
      busy          <= (|cnt_nxt) || (|csr_vld_nxt);
      err_underflow <= err_underflow || (|gpr_uf) || rel_uf;
    end
  end

  // Trap-drain FSM: accept trap_req only in RUN, wait for registered busy to drop, then hold ACK for one cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else begin
      case (state)
        S_RUN:   if (trap_req) state <= S_DRAIN;
        S_DRAIN: if (!busy)    state <= S_ACK;
        S_ACK:                 state <= S_RUN;
        default:               state <= S_RUN;
      endcase
    end
  end

  assign trap_ack = state == S_ACK;
endmodule
